// File: rtl/vxe_ctrl_regs.sv
// Control/status register bank behind the AXI4 slave BIU: programming registers,
// start/run/done engine FSM and maskable interrupt. Optional macro: VXE_CTRL_SCRATCH_EN.
module vxe_ctrl_regs #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] VXE_ID     = 32'h5658_0100
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [ADDR_WIDTH-1:0]   biu_waddr,
  input  logic                    biu_wenable,
  input  logic [DATA_WIDTH-1:0]   biu_wdata,
  input  logic [DATA_WIDTH/8-1:0] biu_wben,
  output logic                    biu_waccept,
  output logic                    biu_werror,
  input  logic [ADDR_WIDTH-1:0]   biu_raddr,
  input  logic                    biu_renable,
  output logic [DATA_WIDTH-1:0]   biu_rdata,
  output logic                    biu_raccept,
  output logic                    biu_rerror,
  output logic                    o_start,
  output logic [63:0]             o_pgm_addr,
  input  logic                    i_busy,
  input  logic                    i_done,
  input  logic                    i_err,
  output logic                    o_intr
);

  localparam logic [2:0] IDX_ID     = 3'd0;
  localparam logic [2:0] IDX_CTRL   = 3'd1;
  localparam logic [2:0] IDX_STATUS = 3'd2;
  localparam logic [2:0] IDX_ACT    = 3'd3;
  localparam logic [2:0] IDX_MSK    = 3'd4;
  localparam logic [2:0] IDX_PGM_LO = 3'd5;
  localparam logic [2:0] IDX_PGM_HI = 3'd6;
`ifdef VXE_CTRL_SCRATCH_EN
  localparam logic [2:0] IDX_SCR    = 3'd7;
  localparam bit         SCR_EN     = 1'b1;
`else
  localparam bit         SCR_EN     = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            act_reg, act_next, msk_reg;
  logic [DATA_WIDTH-1:0] pgm_lo_reg, pgm_hi_reg;
  logic                  intr_reg;
  logic                  waccept_reg, werror_reg;
  logic                  raccept_reg, rerror_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
`ifdef VXE_CTRL_SCRATCH_EN
  logic [DATA_WIDTH-1:0] scr_reg;
  logic                  scr_we;
`endif

  logic [DATA_WIDTH-1:0] wmask;
  for (genvar gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_wmask
    assign wmask[gi*8 +: 8] = {8{biu_wben[gi]}};
  end

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_val,
                                                  input logic [DATA_WIDTH-1:0] new_val,
                                                  input logic [DATA_WIDTH-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // A new request is taken only outside the accept cycle, so a held enable is not double-counted.
  logic       wr_fire, rd_fire;
  logic [2:0] w_idx, r_idx;
  logic       w_valid, r_valid;

  assign wr_fire = biu_wenable && !waccept_reg;
  assign rd_fire = biu_renable && !raccept_reg;
  assign w_idx   = biu_waddr[4:2];
  assign r_idx   = biu_raddr[4:2];
  assign w_valid = (biu_waddr[1:0] == 2'b00) && (biu_waddr[ADDR_WIDTH-1:5] == '0) &&
                   ((w_idx != 3'd7) || SCR_EN);
  assign r_valid = (biu_raddr[1:0] == 2'b00) && (biu_raddr[ADDR_WIDTH-1:5] == '0) &&
                   ((r_idx != 3'd7) || SCR_EN);

  logic       wr_err, start_wr, msk_we, pgm_lo_we, pgm_hi_we;
  logic [1:0] act_clr;

  always_comb begin
    wr_err    = 1'b0;
    start_wr  = 1'b0;
    msk_we    = 1'b0;
    pgm_lo_we = 1'b0;
    pgm_hi_we = 1'b0;
    act_clr   = 2'b00;
`ifdef VXE_CTRL_SCRATCH_EN
    scr_we    = 1'b0;
`endif
    if (wr_fire) begin
      if (!w_valid) begin
        wr_err = 1'b1;
      end else begin
        case (w_idx)
          IDX_ID, IDX_STATUS: wr_err = 1'b1;
          IDX_CTRL: begin
            if (biu_wben[0] && biu_wdata[0]) begin
              if (state_reg != ST_IDLE) wr_err = 1'b1;
              else                      start_wr = 1'b1;
            end
          end
          IDX_ACT: act_clr = biu_wdata[1:0] & wmask[1:0];
          IDX_MSK: msk_we = 1'b1;
          IDX_PGM_LO: begin
            if (state_reg != ST_IDLE) wr_err = 1'b1;
            else                      pgm_lo_we = 1'b1;
          end
          IDX_PGM_HI: begin
            if (state_reg != ST_IDLE) wr_err = 1'b1;
            else                      pgm_hi_we = 1'b1;
          end
`ifdef VXE_CTRL_SCRATCH_EN
          IDX_SCR: scr_we = 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  // Engine FSM; completion sets INTR_ACT after the W1C clear so hardware set wins.
  logic done_set, err_set;

  always_comb begin
    state_next = state_reg;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state_reg)
      ST_IDLE:  if (start_wr) state_next = ST_START;
      ST_START: if (i_busy)   state_next = ST_RUN;
      ST_RUN: begin
        if (i_done) begin
          state_next = ST_IDLE;
          done_set   = 1'b1;
          err_set    = i_err;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    act_next = (act_reg & ~act_clr) | {err_set, done_set};
  end

  logic [DATA_WIDTH-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (r_idx)
      IDX_ID:     rd_val = VXE_ID;
      IDX_STATUS: rd_val[0] = (state_reg != ST_IDLE);
      IDX_ACT:    rd_val[1:0] = act_reg;
      IDX_MSK:    rd_val[1:0] = msk_reg;
      IDX_PGM_LO: rd_val = pgm_lo_reg;
      IDX_PGM_HI: rd_val = pgm_hi_reg;
`ifdef VXE_CTRL_SCRATCH_EN
      IDX_SCR:    rd_val = scr_reg;
`endif
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= ST_IDLE;
      act_reg     <= 2'b00;
      msk_reg     <= 2'b00;
      pgm_lo_reg  <= '0;
      pgm_hi_reg  <= '0;
      intr_reg    <= 1'b0;
      waccept_reg <= 1'b0;
      werror_reg  <= 1'b0;
      raccept_reg <= 1'b0;
      rerror_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      act_reg     <= act_next;
      if (msk_we)    msk_reg    <= (msk_reg & ~wmask[1:0]) | (biu_wdata[1:0] & wmask[1:0]);
      if (pgm_lo_we) pgm_lo_reg <= merge(pgm_lo_reg, biu_wdata, wmask);
      if (pgm_hi_we) pgm_hi_reg <= merge(pgm_hi_reg, biu_wdata, wmask);
      intr_reg    <= |(act_reg & msk_reg);
      waccept_reg <= wr_fire;
      werror_reg  <= wr_fire && wr_err;
      raccept_reg <= rd_fire;
      rerror_reg  <= rd_fire && !r_valid;
      rdata_reg   <= (rd_fire && r_valid) ? rd_val : '0;
    end
  end

`ifdef VXE_CTRL_SCRATCH_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       scr_reg <= '0;
    else if (scr_we) scr_reg <= merge(scr_reg, biu_wdata, wmask);
  end
`endif

  assign biu_waccept = waccept_reg;
  assign biu_werror  = werror_reg;
  assign biu_raccept = raccept_reg;
  assign biu_rerror  = rerror_reg;
  assign biu_rdata   = rdata_reg;
  assign o_start     = (state_reg == ST_START);
  assign o_pgm_addr  = {pgm_hi_reg, pgm_lo_reg};
  assign o_intr      = intr_reg;

endmodule

// File: tb/tb_vxe_ctrl_regs.sv
// Scoreboard bench for vxe_ctrl_regs: directed scenarios then randomized register and
// engine traffic against a register-map reference model. Honours VXE_CTRL_SCRATCH_EN.
module tb_vxe_ctrl_regs;
  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] biu_waddr, biu_wdata, biu_raddr, biu_rdata;
  logic [3:0]  biu_wben;
  logic        biu_wenable, biu_waccept, biu_werror;
  logic        biu_renable, biu_raccept, biu_rerror;
  logic        o_start, i_busy, i_done, i_err, o_intr;
  logic [63:0] o_pgm_addr;

  vxe_ctrl_regs dut (
    .clk(clk), .nrst(nrst),
    .biu_waddr(biu_waddr), .biu_wenable(biu_wenable), .biu_wdata(biu_wdata),
    .biu_wben(biu_wben), .biu_waccept(biu_waccept), .biu_werror(biu_werror),
    .biu_raddr(biu_raddr), .biu_renable(biu_renable), .biu_rdata(biu_rdata),
    .biu_raccept(biu_raccept), .biu_rerror(biu_rerror),
    .o_start(o_start), .o_pgm_addr(o_pgm_addr), .i_busy(i_busy), .i_done(i_done),
    .i_err(i_err), .o_intr(o_intr)
  );

  always #5 clk = ~clk;

`ifdef VXE_CTRL_SCRATCH_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif
  localparam int M_IDLE = 0, M_START = 1, M_RUN = 2;

  int checks = 0;
  int errors = 0;

  // Reference model of the programmer-visible state.
  logic [1:0]  m_act, m_msk;
  logic [31:0] m_lo, m_hi, m_scr;
  int          m_st;

  logic [31:0] rq_data[$];
  logic        rq_err[$];
  logic [31:0] rq_addr[$];
  logic        wq_err[$];
  logic [31:0] wq_addr[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] ben);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (ben[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32) && (a != 32'h1C || SCR);
  endfunction

  task automatic model_reset();
    m_act = 0; m_msk = 0; m_lo = 0; m_hi = 0; m_scr = 0; m_st = M_IDLE;
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    d = 0;
    e = !addr_ok(a);
    if (!e) begin
      case (a)
        32'h00: d = 32'h5658_0100;
        32'h08: d = (m_st != M_IDLE) ? 32'd1 : 32'd0;
        32'h0C: d = {30'd0, m_act};
        32'h10: d = {30'd0, m_msk};
        32'h14: d = m_lo;
        32'h18: d = m_hi;
        32'h1C: d = m_scr;
        default: d = 0;
      endcase
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ben,
                             output logic e);
    e = !addr_ok(a);
    if (!e) begin
      case (a)
        32'h00, 32'h08: e = 1;
        32'h04: if (ben[0] && d[0]) begin
                  if (m_st != M_IDLE) e = 1; else m_st = M_START;
                end
        32'h0C: if (ben[0]) m_act = m_act & ~d[1:0];
        32'h10: if (ben[0]) m_msk = d[1:0];
        32'h14: if (m_st != M_IDLE) e = 1; else m_lo = merge(m_lo, d, ben);
        32'h18: if (m_st != M_IDLE) e = 1; else m_hi = merge(m_hi, d, ben);
        32'h1C: m_scr = merge(m_scr, d, ben);
        default: ;
      endcase
    end
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [31:0] d; logic e; int n;
    model_read(a, d, e);
    rq_data.push_back(d); rq_err.push_back(e); rq_addr.push_back(a);
    biu_raddr = a; biu_renable = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!biu_raccept && n < 5);
    biu_renable = 0;
    chk($sformatf("rd_latency@%h", a), n, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ben);
    logic e; int n;
    model_write(a, d, ben, e);
    wq_err.push_back(e); wq_addr.push_back(a);
    biu_waddr = a; biu_wdata = d; biu_wben = ben; biu_wenable = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!biu_waccept && n < 5);
    biu_wenable = 0;
    chk($sformatf("wr_latency@%h", a), n, 1);
    @(posedge clk); #1;
  endtask

  task automatic eng_busy();
    i_busy = 1;
    if (m_st == M_START) m_st = M_RUN;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic eng_done(input logic e);
    i_done = 1; i_err = e;
    if (m_st == M_RUN) begin m_act[0] = 1; m_act[1] = m_act[1] | e; m_st = M_IDLE; end
    @(posedge clk); #1;
    i_done = 0; i_err = 0; i_busy = 0;
    @(posedge clk); #1;
  endtask

  // W1C of INTR_ACT bit0 landing on the same edge as the engine's done pulse.
  task automatic w1c_with_done();
    int n;
    wq_err.push_back(1'b0); wq_addr.push_back(32'h0C);
    m_act[0] = 1; m_st = M_IDLE;
    biu_waddr = 32'h0C; biu_wdata = 32'h1; biu_wben = 4'hF; biu_wenable = 1;
    i_done = 1; i_err = 0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!biu_waccept && n < 5);
    biu_wenable = 0; i_done = 0; i_busy = 0;
    chk("w1c_done_latency", n, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_o_start"}, o_start, (m_st == M_START));
    chk({tag, "_o_pgm_addr"}, o_pgm_addr, {m_hi, m_lo});
    chk({tag, "_o_intr"}, o_intr, |(m_act & m_msk));
  endtask

  // Monitor: every accept pulse consumes exactly one scoreboard entry.
  always @(negedge clk) begin
    if (biu_raccept) begin
      if (rq_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected actual=accept required=none");
      end else begin
        logic [31:0] d, a; logic e;
        d = rq_data.pop_front(); e = rq_err.pop_front(); a = rq_addr.pop_front();
        chk($sformatf("rdata@%h", a), biu_rdata, d);
        chk($sformatf("rerror@%h", a), biu_rerror, e);
      end
    end
    if (biu_waccept) begin
      if (wq_err.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected actual=accept required=none");
      end else begin
        logic [31:0] a; logic e;
        e = wq_err.pop_front(); a = wq_addr.pop_front();
        chk($sformatf("werror@%h", a), biu_werror, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pick_addr();
    int k;
    k = $urandom_range(0, 10);
    if (k < 8) return 32'(k * 4);
    if (k == 8) return 32'h0E;
    if (k == 9) return 32'h40;
    return 32'($urandom_range(0, 63));
  endfunction

  initial begin
    nrst = 0; biu_wenable = 0; biu_renable = 0; biu_waddr = 0; biu_raddr = 0;
    biu_wdata = 0; biu_wben = 0; i_busy = 0; i_done = 0; i_err = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waccept", biu_waccept, 0);
    chk("rst_raccept", biu_raccept, 0);
    check_outs("rst");
    nrst = 1;
    @(posedge clk); #1;

    do_read(32'h00);
    do_read(32'h08);
    do_write(32'h14, 32'hf1f2_f3f4, 4'b0011);
    do_read(32'h14);
    check_outs("pgm_lo");

    do_write(32'h04, 32'h1, 4'hF);
    check_outs("start");
    do_read(32'h08);
    eng_busy();
    check_outs("run");
    do_write(32'h14, 32'hdead_beef, 4'hF);
    do_read(32'h14);
    do_read(32'h08);
    eng_done(1'b1);
    do_read(32'h0C);
    do_read(32'h08);

    do_write(32'h0C, 32'h3, 4'h1);
    do_write(32'h10, 32'h1, 4'h1);
    do_write(32'h04, 32'h1, 4'h1);
    eng_busy();
    eng_done(1'b0);
    check_outs("intr_on");
    do_write(32'h04, 32'h1, 4'h1);
    eng_busy();
    w1c_with_done();
    do_read(32'h0C);
    check_outs("set_wins");
    do_write(32'h0C, 32'h1, 4'h1);
    check_outs("intr_off");

    do_read(32'h0E);
    do_read(32'h40);
    do_read(32'h1C);
    do_write(32'h00, 32'h1234_5678, 4'hF);
    do_write(32'h1C, 32'h0bad_cafe, 4'hF);
    do_read(32'h1C);

    fork
      do_read(32'h00);
      do_write(32'h18, 32'h0000_00a5, 4'hF);
    join
    check_outs("concurrent");

    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 4) do_read(pick_addr());
      else if (op < 8) do_write(pick_addr(), $urandom, 4'($urandom_range(0, 15)));
      else if (m_st == M_START && $urandom_range(0, 3) != 0) eng_busy();
      else eng_done(1'($urandom_range(0, 1)));
      check_outs("rand");
    end

    // Asynchronous reset while the engine is running.
    do_write(32'h10, 32'h3, 4'h1);
    do_write(32'h14, 32'h1111_2222, 4'hF);
    if (m_st == M_IDLE) do_write(32'h04, 32'h1, 4'h1);
    if (m_st == M_START) eng_busy();
    do_read(32'h08);
    #3;
    nrst = 0;
    model_reset();
    #1;
    check_outs("async_rst");
    chk("async_rst_waccept", biu_waccept, 0);
    @(posedge clk); #2;
    i_busy = 0;
    nrst = 1;
    @(posedge clk); #1;
    do_read(32'h08);
    do_read(32'h14);
    do_read(32'h10);
    do_write(32'h04, 32'h1, 4'h1);
    check_outs("relaunch");
    eng_busy();
    eng_done(1'b0);
    do_read(32'h0C);

    @(posedge clk); #1;
    chk("rq_drained", rq_data.size(), 0);
    chk("wq_drained", wq_err.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
